// File: rtl/pwm_symbol_rx.sv
// rtl/pwm_symbol_rx.sv - pulse-width-coded single-line word receiver
//
// Purpose: synchronizes X_IN, measures each high pulse in CLK cycles,
// classifies it as bit 0 (short) or bit 1 (long), and shifts the bits
// MSB-first into an NBITS word. Malformed pulses, over-long pulses and
// inter-bit gap timeouts discard the partial word and strobe ERR.
//
// Ports:
//   CLK        in   clock, rising edge
//   nRST       in   synchronous reset, active-high
//   X_IN       in   asynchronous serial line
//   DATA_OUT   out  last completed word, held until the next one
//   DATA_VALID out  one-cycle strobe, DATA_OUT updated this cycle
//   ERR        out  one-cycle strobe, frame discarded
//   BUSY       out  high while a word is in progress
//   BIT_CNT    out  bits received in the current word
module pwm_symbol_rx #(
  parameter int NBITS       = 8,
  parameter int SHORT_MIN   = 2,
  parameter int SHORT_MAX   = 4,
  parameter int LONG_MIN    = 6,
  parameter int LONG_MAX    = 10,
  parameter int GAP_TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             X_IN,
  output logic [NBITS-1:0] DATA_OUT,
  output logic             DATA_VALID,
  output logic             ERR,
  output logic             BUSY,
  output logic [3:0]       BIT_CNT
);

  localparam logic [7:0] S_MIN = 8'(SHORT_MIN);
  localparam logic [7:0] S_MAX = 8'(SHORT_MAX);
  localparam logic [7:0] L_MIN = 8'(LONG_MIN);
  localparam logic [7:0] L_MAX = 8'(LONG_MAX);
  localparam logic [7:0] W_SAT = 8'(LONG_MAX + 1);
  localparam logic [7:0] G_TO  = 8'(GAP_TIMEOUT);
  localparam logic [3:0] NB    = 4'(NBITS);

  typedef enum logic [1:0] {IDLE, HIGH, GAP, DRAIN} state_t;

  state_t           state, state_next;
  logic             sync1, x_s, x_d;
  logic             rise, fall;
  logic [7:0]       wcnt, gcnt;
  logic [NBITS-1:0] shreg, shreg_next, data_next;
  logic [3:0]       bit_cnt_next, bit_cnt_inc;
  logic             valid_next, err_next;
  logic             w_short, w_long;

  assign rise        = x_s & ~x_d;
  assign fall        = ~x_s & x_d;
  assign w_short     = (wcnt >= S_MIN) && (wcnt <= S_MAX);
  assign w_long      = (wcnt >= L_MIN) && (wcnt <= L_MAX);
  assign bit_cnt_inc = BIT_CNT + 4'd1;

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = BIT_CNT;
    data_next    = DATA_OUT;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_next = HIGH;
      end
      HIGH: begin
        if (fall) begin
          if (w_short || w_long) begin
            if (bit_cnt_inc == NB) begin
              data_next    = {shreg[NBITS-2:0], w_long};
              valid_next   = 1'b1;
              shreg_next   = '0;
              bit_cnt_next = 4'd0;
              state_next   = IDLE;
            end else begin
              shreg_next   = {shreg[NBITS-2:0], w_long};
              bit_cnt_next = bit_cnt_inc;
              state_next   = GAP;
            end
          end else begin
            err_next     = 1'b1;
            shreg_next   = '0;
            bit_cnt_next = 4'd0;
            state_next   = IDLE;
          end
        end else if (x_s && (wcnt == W_SAT)) begin
          // Already too long to be a bit; wait out the pulse before flagging.
          state_next = DRAIN;
        end
      end
      GAP: begin
        if (rise) begin
          state_next = HIGH;
        end else if (!x_s && (gcnt == G_TO)) begin
          err_next     = 1'b1;
          shreg_next   = '0;
          bit_cnt_next = 4'd0;
          state_next   = IDLE;
        end
      end
      DRAIN: begin
        if (fall) begin
          err_next     = 1'b1;
          shreg_next   = '0;
          bit_cnt_next = 4'd0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      // Sync chain preset high so a line already high at release is no rise.
      sync1      <= 1'b1;
      x_s        <= 1'b1;
      x_d        <= 1'b1;
      wcnt       <= 8'd0;
      gcnt       <= 8'd0;
      state      <= IDLE;
      shreg      <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      ERR        <= 1'b0;
      BUSY       <= 1'b0;
      BIT_CNT    <= 4'd0;
    end else begin
      sync1 <= X_IN;
      x_s   <= sync1;
      x_d   <= x_s;

      if (rise)                      wcnt <= 8'd1;
      else if (x_s && wcnt < W_SAT)  wcnt <= wcnt + 8'd1;

      // Saturate so unlimited idle low time never wraps the counter.
      if (fall)                          gcnt <= 8'd1;
      else if (!x_s && gcnt != 8'hFF)    gcnt <= gcnt + 8'd1;

      state      <= state_next;
      shreg      <= shreg_next;
      DATA_OUT   <= data_next;
      DATA_VALID <= valid_next;
      ERR        <= err_next;
      BUSY       <= (state_next != IDLE);
      BIT_CNT    <= bit_cnt_next;
    end
  end

endmodule

// File: tb/tb_pwm_symbol_rx.sv
// tb/tb_pwm_symbol_rx.sv - self-checking bench for pwm_symbol_rx
module tb_pwm_symbol_rx;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       X_IN;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID;
  logic       ERR;
  logic       BUSY;
  logic [3:0] BIT_CNT;

  pwm_symbol_rx dut (
    .CLK(CLK), .nRST(nRST), .X_IN(X_IN),
    .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .ERR(ERR),
    .BUSY(BUSY), .BIT_CNT(BIT_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int         n_valid = 0, n_err = 0, n_both = 0;
  int         valid_cyc = -1, err_cyc = -1;
  logic [7:0] vq[$];

  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
      vq.push_back(DATA_OUT);
    end
    if (ERR === 1'b1) begin
      n_err   = n_err + 1;
      err_cyc = cyc;
    end
    if (DATA_VALID === 1'b1 && ERR === 1'b1) n_both = n_both + 1;
  end

  int passed = 0, total = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse(int w, int g, output int low_cyc);
    X_IN = 1'b1;
    tick(w);
    X_IN = 1'b0;
    low_cyc = cyc;
    tick(g);
  endtask

  task automatic send_word(logic [7:0] word, int w1, int w0, int gap, int tail,
                           output int last_low);
    for (int i = 7; i >= 0; i--)
      pulse(word[i] ? w1 : w0, (i == 0) ? tail : gap, last_low);
  endtask

  typedef struct {
    logic [7:0] word;
    int         w1;
    int         w0;
    int         gap;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lowc, v0, e0, qb;

    tbl[0] = '{8'hA5, 8,  3, 3,  8'hA5};
    tbl[1] = '{8'h5A, 6,  2, 2,  8'h5A};
    tbl[2] = '{8'hC3, 10, 4, 5,  8'hC3};
    tbl[3] = '{8'h81, 7,  3, 16, 8'h81};
    tbl[4] = '{8'h00, 8,  2, 1,  8'h00};
    tbl[5] = '{8'h7E, 9,  4, 1,  8'h7E};

    nRST = 1'b1;
    X_IN = 1'b0;
    tick(3);
    nRST = 1'b0;
    check("rst_data", DATA_OUT, 8'h00);
    check("rst_valid", DATA_VALID, 1'b0);
    check("rst_err", ERR, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_bitcnt", BIT_CNT, 4'd0);
    tick(4);

    // Table-driven words
    for (int t = 0; t < 6; t++) begin
      v0 = n_valid;
      e0 = n_err;
      send_word(tbl[t].word, tbl[t].w1, tbl[t].w0, tbl[t].gap, 6, lowc);
      check($sformatf("tbl%0d_nvalid", t), n_valid - v0, 1);
      check($sformatf("tbl%0d_nerr", t), n_err - e0, 0);
      check($sformatf("tbl%0d_lat", t), valid_cyc, lowc + 3);
      check($sformatf("tbl%0d_data", t), vq[vq.size()-1], tbl[t].exp_data);
      check($sformatf("tbl%0d_hold", t), DATA_OUT, tbl[t].exp_data);
      check($sformatf("tbl%0d_bitcnt", t), BIT_CNT, 4'd0);
      check($sformatf("tbl%0d_busy", t), BUSY, 1'b0);
    end

    // Back-to-back words with one idle cycle between
    qb = vq.size();
    e0 = n_err;
    send_word(8'h3C, 8, 3, 3, 1, lowc);
    send_word(8'hFF, 8, 3, 3, 6, lowc);
    check("b2b_count", vq.size() - qb, 2);
    check("b2b_first", vq[qb], 8'h3C);
    check("b2b_second", vq[qb+1], 8'hFF);
    check("b2b_lat", valid_cyc, lowc + 3);
    check("b2b_nerr", n_err - e0, 0);

    // 5-cycle pulse falls between the classes
    v0 = n_valid;
    e0 = n_err;
    pulse(8, 3, lowc);
    pulse(3, 3, lowc);
    check("bad_bitcnt_pre", BIT_CNT, 4'd2);
    pulse(5, 6, lowc);
    check("bad_nerr", n_err - e0, 1);
    check("bad_lat", err_cyc, lowc + 3);
    check("bad_nvalid", n_valid - v0, 0);
    check("bad_data_kept", DATA_OUT, 8'hFF);
    check("bad_bitcnt", BIT_CNT, 4'd0);
    check("bad_busy", BUSY, 1'b0);

    // 1-cycle pulse from idle is below SHORT_MIN
    e0 = n_err;
    pulse(1, 6, lowc);
    check("short1_nerr", n_err - e0, 1);

    // 14-cycle pulse drives DRAIN; ERR only after the fall
    v0 = n_valid;
    e0 = n_err;
    pulse(3, 3, lowc);
    pulse(8, 3, lowc);
    X_IN = 1'b1;
    tick(13);
    check("drain_no_err_yet", n_err - e0, 0);
    check("drain_busy", BUSY, 1'b1);
    check("drain_bitcnt_mid", BIT_CNT, 4'd2);
    tick(1);
    X_IN = 1'b0;
    lowc = cyc;
    tick(6);
    check("drain_nerr", n_err - e0, 1);
    check("drain_lat", err_cyc, lowc + 3);
    check("drain_bitcnt", BIT_CNT, 4'd0);
    check("drain_nvalid", n_valid - v0, 0);

    // Gap timeout after 3 good bits
    v0 = n_valid;
    e0 = n_err;
    pulse(8, 3, lowc);
    pulse(3, 3, lowc);
    pulse(8, 30, lowc);
    check("gap_nerr", n_err - e0, 1);
    check("gap_lat", err_cyc, lowc + 19);
    check("gap_busy", BUSY, 1'b0);
    check("gap_bitcnt", BIT_CNT, 4'd0);
    send_word(8'h81, 8, 3, 3, 6, lowc);
    check("gap_next_nvalid", n_valid - v0, 1);
    check("gap_next_data", DATA_OUT, 8'h81);
    check("gap_next_nerr", n_err - e0, 1);

    // Reset mid-word with line held high through release
    v0 = n_valid;
    e0 = n_err;
    pulse(8, 3, lowc);
    pulse(3, 3, lowc);
    pulse(8, 3, lowc);
    pulse(8, 3, lowc);
    check("mid_bitcnt_pre", BIT_CNT, 4'd4);
    X_IN = 1'b1;
    tick(2);
    nRST = 1'b1;
    tick(1);
    nRST = 1'b0;
    check("mid_rst_data", DATA_OUT, 8'h00);
    check("mid_rst_bitcnt", BIT_CNT, 4'd0);
    check("mid_rst_busy", BUSY, 1'b0);
    check("mid_rst_valid", DATA_VALID, 1'b0);
    check("mid_rst_err", ERR, 1'b0);
    tick(5);
    check("mid_high_busy", BUSY, 1'b0);
    X_IN = 1'b0;
    tick(6);
    check("mid_low_busy", BUSY, 1'b0);
    check("mid_low_bitcnt", BIT_CNT, 4'd0);
    check("mid_nerr", n_err - e0, 0);
    check("mid_nvalid", n_valid - v0, 0);
    send_word(8'h5A, 8, 3, 3, 6, lowc);
    check("mid_next_nvalid", n_valid - v0, 1);
    check("mid_next_data", DATA_OUT, 8'h5A);
    check("mid_next_lat", valid_cyc, lowc + 3);

    check("never_both", n_both, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_symbol_rx.md
Name: pwm_symbol_rx

Overview:
- Receiver for the single-line pulse-width-coded link whose transmitter drives a shaped pulse train from a one-shot state machine.
- Measures each high pulse on X_IN in CLK cycles and classifies it as bit 0 (short) or bit 1 (long). Shifts bits MSB-first into a word and presents each completed word with a one-cycle valid strobe.
- Flags malformed pulses and inter-bit gap timeouts on ERR.
- Sits between the asynchronous line input and the downstream word consumer.

Parameters:
- NBITS, 8, bits per word (2..15)
- SHORT_MIN, 2, minimum high width in cycles for bit 0
- SHORT_MAX, 4, maximum high width for bit 0
- LONG_MIN, 6, minimum high width for bit 1
- LONG_MAX, 10, maximum high width for bit 1; must be < 255
- GAP_TIMEOUT, 16, low cycles allowed between bits inside a word; must be < 255

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  reset, synchronous, active-high (nRST=1 resets)
- X_IN  input  1  asynchronous serial line
- DATA_OUT  output  NBITS  last completed word; held until next word
- DATA_VALID  output  1  one-cycle strobe, DATA_OUT updated this cycle
- ERR  output  1  one-cycle strobe, frame discarded
- BUSY  output  1  high whenever state != IDLE
- BIT_CNT  output  4  bits received in current word

Behaviour:
- Reset (nRST=1 at a CLK edge):
  - DATA_OUT=0, DATA_VALID=0, ERR=0, BUSY=0, BIT_CNT=0, state=IDLE.
  - Shift register and counters are cleared.
  - Both synchronizer flops are set to 1, so a line already high at reset release is never measured as a pulse.
  - Reset mid-word discards the partial word with no ERR.
- Input path:
  - 2-flop synchronizer gives x_s; x_d = x_s delayed 1 cycle.
  - rise = x_s & ~x_d; fall = ~x_s & x_d.
- Width counter wcnt (8 bit):
  - Loaded with 1 on rise.
  - Increments each cycle x_s=1.
  - Saturates at LONG_MAX+1.
- Gap counter gcnt (8 bit):
  - Loaded with 1 on fall.
  - Increments each cycle x_s=0.
- States: IDLE, HIGH, GAP, DRAIN.
  - IDLE: fall ignored. rise -> HIGH.
  - HIGH: fall classifies w=wcnt.
    - SHORT_MIN<=w<=SHORT_MAX -> bit 0.
    - LONG_MIN<=w<=LONG_MAX -> bit 1.
    - Any other w -> ERR pulse, clear shift register and BIT_CNT, -> IDLE.
    - Valid bit: shreg <= {shreg[NBITS-2:0], bit}; BIT_CNT+1.
    - If BIT_CNT reaches NBITS: DATA_OUT <= completed word, DATA_VALID pulse, BIT_CNT=0, -> IDLE. Otherwise -> GAP.
    - wcnt reaching LONG_MAX+1 while x_s=1 -> DRAIN.
  - GAP: rise -> HIGH. If gcnt reaches GAP_TIMEOUT with x_s still 0 -> ERR pulse, discard partial word, -> IDLE.
  - DRAIN: wait for fall -> ERR pulse, discard, -> IDLE.
- Latency:
  - Call the CLK edge that first samples X_IN low after the last pulse of a word edge k.
  - DATA_VALID (or ERR for a bad width) is high for the cycle following edge k+2.
- Outputs are registered. DATA_VALID and ERR are never high in the same cycle. Each is high for exactly one cycle per event.
- Pulse width accounting: a pulse of N cycles on X_IN (constant, setup-clean) measures w=N.
- Simultaneous events: a valid completed word wins; no gap timeout is evaluated in the cycle of classification.
- Back-to-back words: after DATA_VALID, IDLE accepts a rise on the very next cycle.
- BUSY is not asserted in IDLE. Idle low time is unlimited; GAP_TIMEOUT applies only inside a word.

Test Plan:
- Send 0xA5 MSB-first: bit1 = 8-cycle high, bit0 = 3-cycle high, 3-cycle gaps. Expect DATA_OUT=0xA5, DATA_VALID one cycle at edge k+2, ERR=0, BIT_CNT back to 0.
- Two words 0x3C then 0xFF with 1-cycle idle between them. Expect two DATA_VALID strobes, DATA_OUT=0x3C then 0xFF, no ERR.
- Width boundaries: pulses of 2, 4, 6 and 10 cycles are accepted. A 5-cycle pulse gives ERR at edge k+2, no DATA_VALID, DATA_OUT keeps its previous value.
- 14-cycle high pulse after 2 good bits: enter DRAIN at wcnt=11, ERR only after the line falls, BIT_CNT=0.
- Gap timeout: 3 good bits then line low 16+ cycles. Expect ERR exactly once, BUSY drops, a following full word 0x81 is received correctly.
- Assert nRST for 1 cycle after 4 bits with X_IN held high through release. Expect all outputs 0, no pulse counted until the next true rise, then a full word 0x5A decodes correctly.
